// File: rtl/arbitro_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_pkg: shared types and helpers for the write-port arbiter     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package arbitro_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int REG_ADDR_W = 4;

  // Index width for v entries, never below one bit.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prioridad_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | prioridad_rr: combinational round-robin picker, search from last+1   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module prioridad_rr #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = 0;
    for (int off = 1; off <= NREQ; off++) begin
      w_cand = (int'(last) + off) % NREQ;
      if (!any && elig[w_cand]) begin
        any         = 1'b1;
        idx         = IDX_W'(w_cand);
        gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arbitro_escritura.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arbitro_escritura: round-robin arbiter with lock for the bank port   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module arbitro_escritura
  import arbitro_pkg::*;
#(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         lock,
  input  logic [REG_ADDR_W*NREQ-1:0] addr,
  input  logic [N*NREQ-1:0]       data,
  output logic [NREQ-1:0]         ack,
  output logic                    w,
  output logic [REG_ADDR_W-1:0]   select_register,
  output logic [N-1:0]            s,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  localparam int IDX_W = clog2(NREQ);

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_last, r_owner, w_owner_nxt, w_idx;
  logic [NREQ-1:0]  w_elig, w_gnt;
  logic             w_any, w_hold;

  // The requester acked this cycle has not yet seen its ack, so it is masked.
  always_comb begin
    w_hold = (r_state == LOCKED) && lock[r_owner];
    w_elig = req & ~ack;
    if (w_hold)
      w_elig = w_elig & (NREQ'(1) << r_owner);
  end

  prioridad_rr #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_prioridad (
    .elig (w_elig),
    .last (r_last),
    .gnt  (w_gnt),
    .idx  (w_idx),
    .any  (w_any)
  );

  always_comb begin
    w_state_nxt = ARB;
    w_owner_nxt = r_owner;
    if (w_hold) begin
      w_state_nxt = LOCKED;
    end else if (w_any && lock[w_idx]) begin
      w_state_nxt = LOCKED;
      w_owner_nxt = w_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last          <= IDX_W'(NREQ - 1);
      w               <= 1'b0;
      ack             <= '0;
      select_register <= '0;
      s               <= '0;
      grant_id        <= '0;
    end else begin
      w   <= w_any;
      ack <= w_gnt;
      if (w_any) begin
        r_last          <= w_idx;
        select_register <= addr[REG_ADDR_W*w_idx +: REG_ADDR_W];
        s               <= data[N*w_idx +: N];
        grant_id        <= 3'(w_idx);
      end
    end
  end

  assign busy = (r_state == LOCKED);

endmodule
`default_nettype wire
